// File: rtl/multiplier_4_bit_seq_pkg.sv
// Shared definitions for the MAC datapath stages: FSM state encoding and
// operand/iteration sizing used by the multiplier, adder and accumulator.
package multiplier_4_bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W   = 4;
  localparam int ITER_COUNT = 4;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/multiplier_4_bit_seq_adder_4_bit.sv
// 4-bit ripple-carry adder used by the multiplier for the partial-product
// accumulate step; each bit is a plain full-adder cell.
module adder_4_bit
  import multiplier_4_bit_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/multiplier_4_bit_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier with valid/ready on both
// sides; the product is held in two nibble registers until consumed.
module multiplier_4_bit_seq
  import multiplier_4_bit_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] multiplicand,
  input  logic [NIBBLE_W-1:0] multiplier,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] product_low,
  output logic [NIBBLE_W-1:0] product_high,
  output logic                busy
);

  state_t               state;
  logic [NIBBLE_W-1:0]  a_reg;
  logic [NIBBLE_W-1:0]  q;
  logic [NIBBLE_W-1:0]  p;
  logic [CNT_W-1:0]     cnt;

  logic [NIBBLE_W-1:0]  addend;
  logic [NIBBLE_W-1:0]  sum;
  logic                 carry;
  logic [NIBBLE_W-1:0]  p_next;
  logic [NIBBLE_W-1:0]  q_next;

  assign addend = q[0] ? a_reg : '0;

  adder_4_bit u_adder (
    .a    (p),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // The carry is shifted straight into P, so no separate C register is kept.
  assign p_next = {carry, sum[NIBBLE_W-1:1]};
  assign q_next = {sum[0], q[NIBBLE_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_reg        <= '0;
      q            <= '0;
      p            <= '0;
      cnt          <= '0;
      product_low  <= '0;
      product_high <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= multiplicand;
            q        <= multiplier;
            p        <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            product_high <= p_next;
            product_low  <= q_next;
            state        <= DONE;
            busy         <= 1'b0;
            out_valid    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multiplier_4_bit_seq.md
# multiplier_4_bit_seq

Sequential 4x4-bit unsigned shift-and-add multiplier forming the multiply stage of the MAC unit. Accepts two 4-bit operands over a valid/ready handshake, iterates one multiplier bit per cycle, and presents the 8-bit product as two nibbles, `product_low` and `product_high`. These nibbles drive the `a_low`/`a_high` inputs of the downstream 8-bit accumulate adder. The block holds each result until the consumer takes it.

## Interface
- Parameters: none. Operand width is fixed at 4, the product at 8.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `multiplicand`  in  4  unsigned operand A.
- `multiplier`  in  4  unsigned operand B.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer takes the product.
- `product_low`  out  4  product bits [3:0], to adder `a_low`.
- `product_high`  out  4  product bits [7:4], to adder `a_high`.
- `busy`  out  1  high in CALC.

## Operation
- FSM with three states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On the `in_valid && in_ready` edge: A_reg=multiplicand, Q=multiplier, P=0, C=0, cnt=0, next state CALC.
- CALC, on each edge:
  - If Q[0], {C,P} = P + A_reg (5-bit result); otherwise {C,P} = {0,P}.
  - Then shift {C,P,Q} right by one. Q's LSB is discarded and C is cleared.
  - cnt++.
  - When cnt reaches 3 on this edge (the 4th iteration), load the output register with {P,Q} after the shift. Next state DONE.
- DONE:
  - `out_valid`=1; the product registers are stable.
  - On the `out_valid && out_ready` edge: next state IDLE.
- Handshakes:
  - `in_valid` is ignored outside IDLE.
  - `out_ready` is ignored outside DONE.
- Arithmetic is unsigned and cannot overflow: 15×15 = 225 < 256.
- The output registers hold the last product until the next DONE entry. They are not cleared on leaving DONE.
- Reset: any edge with `rst_n`=0 forces IDLE and clears A_reg, Q, P, C, cnt and both product registers to 0. An in-flight operation is discarded with no output.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `busy`=0.
  - `product_low`=0, `product_high`=0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Latency: with the accept edge as edge 0, CALC runs on edges 1–4 and `out_valid` is high in the cycle after edge 4.
- Minimum initiation interval is 6 cycles (accept, 4×CALC, DONE with `out_ready`=1, IDLE). `in_ready` is low from the accept edge until the cycle after the output handshake.
- Backpressure: with `out_ready`=0, DONE persists indefinitely and the product does not change.
- Simultaneous `rst_n`=0 with any handshake: reset wins and the handshake does not complete.

## Structure
- Shared header, also included by the adder and accumulator stages:
  - state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - NIBBLE_W=4 and ITER_COUNT=4.
- One sub-module: `adder_4_bit`, a 4-bit ripple adder built from the existing full/half-adder cells. It computes P + A_reg with carry out for the CALC step.
- The top level holds the FSM, the datapath registers and the output registers.

## Test plan
- Reset then 0×0 → `out_valid` after 4 CALC cycles; `product_high`=0x0, `product_low`=0x0.
- 15×15 → `product_high`=0xE, `product_low`=0x1 (225); `out_valid` rises exactly 4 edges after accept.
- 7×9 with `out_ready` held low for 10 cycles → `out_valid` and product 0x3F remain stable; `in_ready`=0 throughout; handshake on `out_ready`=1 returns to IDLE.
- Back-to-back 3×5 then 12×4 with `in_valid` held high and `out_ready`=1 → products 0x0F then 0x30; second accept 6 cycles after the first.
- `rst_n` low for one edge during the 2nd CALC cycle of 11×13 → IDLE, all outputs 0, no `out_valid`; a following 2×2 → 0x04.
- Exhaustive: all 256 operand pairs with random `out_ready` stalls → each product equals A×B against a reference model.
